hand_sample_sched: RTL and testbench
====================================

# hand_sample_sched

Sample scheduler in front of `gest_rec`. It shares one sensor read port between the two hand sensors and sequences the six axis reads (x, y, z per hand) once per sample period. Each complete set is committed atomically to the `x1..z2` registers that feed `gest_rec`, so the gesture logic never sees a half-updated frame. It also detects sensor timeouts and period overruns.

## Interface
- `PERIOD_CYCLES`, default 270000: sample period in clocks (100 Hz at 27 MHz); minimum 16.
- `TIMEOUT`, default 255: maximum cycles `rd_req` may stay high without `rd_ack`; range 1..255.
- `W`, default 16: axis sample width.

- `clock`  in  1: system clock. One clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: sampling enabled.
- `rd_req`  out  1: read request on the shared sensor port.
- `rd_hand`  out  1: 0 = hand 1, 1 = hand 2.
- `rd_axis`  out  2: 0 = x, 1 = y, 2 = z (3 is never driven).
- `rd_ack`  in  1: read complete; `rd_data` is valid in the same cycle.
- `rd_data`  in  W: sample value.
- `x1, y1, z1, x2, y2, z2`  out  W each: committed frame.
- `frame_valid`  out  1: one-cycle pulse, high in the first cycle a new frame is visible.
- `frame_err`  out  1: one-cycle pulse when a frame is aborted on timeout.
- `overrun`  out  1: one-cycle pulse when a tick arrives while a frame is in progress.
- `err_count`  out  8: saturating timeout count.
- `busy`  out  1: high in states REQ, GAP and COMMIT.

## Operation
- **Reset:**
  - All outputs go to 0 and the state goes to IDLE.
  - The period counter clears to 0 and `start_hand` clears to 0.
- **Period timer:**
  - Counts 0..`PERIOD_CYCLES`-1 while `enable`=1 and wraps.
  - `tick` is high when the count equals `PERIOD_CYCLES`-1.
  - The timer is held at 0 while `enable`=0.
- **States:**
  - IDLE → REQ on `tick` && `enable`.
  - REQ: drive `rd_req`=1 with `rd_hand`/`rd_axis` stable.
    - If `rd_ack`: capture `rd_data` into the shadow register. Go to GAP, or to COMMIT if this was the 6th read.
    - Otherwise, if the wait counter reaches `TIMEOUT`: go to IDLE, pulse `frame_err`, increment `err_count` (saturating at 255), and discard the shadow.
  - GAP: `rd_req`=0 for exactly one cycle, advance the read index, then go to REQ.
  - COMMIT: load all six outputs from the shadow, set `frame_valid`, toggle `start_hand`, go to IDLE.
- **Read order:**
  - Starts at hand `start_hand`: x, y, z, then the other hand x, y, z.
  - Alternating the starting hand each frame equalises inter-hand sample skew.
- **Wait counter:**
  - Clears on entry to REQ and increments each REQ cycle without `rd_ack`.
  - If `rd_ack` arrives in the cycle the timeout expires, the ack wins.
- **`tick` while not IDLE:** pulse `overrun`; the frame in progress continues; the tick is dropped.
- **`enable` falls mid-frame:**
  - Abort: `rd_req` is low the next cycle and the state goes to IDLE.
  - No commit and no `frame_err`; outputs hold the last frame.
- **Outputs between commits:** `x1..z2` change only in COMMIT and hold otherwise, including after aborts.

## Timing
- **First tick:** `PERIOD_CYCLES` cycles after `enable` rises (tick in cycle E+`PERIOD_CYCLES`-1).
- **Zero-wait ack:** tick in cycle T gives:
  - reads k = 1..6 with `rd_req` high in cycle T+2k-1;
  - COMMIT in T+12;
  - `frame_valid` and new `x1..z2` visible in T+13.
- **Each extra wait cycle** on any read adds one cycle to the frame latency.
- **`rd_req` deassertion:** low for at least one cycle between reads. It is never high in the cycle after an ack.
- **Timeout:** with `rd_ack` never asserted, `rd_req` is high exactly `TIMEOUT` cycles and `frame_err` pulses in the cycle after the last one.

## Structure
- **Shared package `gest_pkg`:**
  - state encoding (IDLE, REQ, GAP, COMMIT);
  - axis codes `AXIS_X`/`AXIS_Y`/`AXIS_Z`;
  - hand codes `HAND_1`/`HAND_2`.
  - `gest_rec` and the sensor interface use the same codes.
- **Sub-module `sample_tick_gen`:** the period counter. Parameter `PERIOD_CYCLES`; inputs `clock`, `reset`, `enable`; output `tick`.
- **Shadow storage:** six W-bit registers indexed by {hand, axis}, written only on ack.

## Test plan
- **Zero-wait frame:** `PERIOD_CYCLES`=16, responder returns `rd_data`={hand,axis,12'h5A0}+axis with an immediate ack → six reads in order x1 y1 z1 x2 y2 z2; `frame_valid` at T+13; `x1`=16'h05A0, `z2`=16'h15A2; next frame starts with hand 2.
- **Wait states:** ack delayed 3 cycles on every read → `frame_valid` at T+31; values correct; no `frame_err`.
- **Timeout:** `TIMEOUT`=4, the 4th read is never acked → `rd_req` high 4 cycles; `frame_err` pulse; `err_count`=1; outputs keep the prior frame; the next tick starts a fresh frame from read 1.
- **Overrun:** `PERIOD_CYCLES`=16 with 2-cycle ack delay (frame is longer than the period) → `overrun` pulses at the mid-frame tick; the frame completes and commits.
- **Enable drop:** `enable`→0 during read 3 → `rd_req` low the next cycle; no `frame_valid`; outputs unchanged; timer at 0.
- **Reset mid-frame and saturation:** `reset` pulsed during REQ → all outputs 0 and `rd_req`=0 the next cycle; then 300 forced timeouts → `err_count` holds at 255.

Source files
------------

// File: rtl/gest_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gest_pkg
//  Description : Codes shared by the sample scheduler, gest_rec and the
//                sensor port: scheduler state encoding, axis codes, hand
//                codes and a read-index helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package gest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_GAP    = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam logic [1:0] AXIS_X = 2'd0;
    localparam logic [1:0] AXIS_Y = 2'd1;
    localparam logic [1:0] AXIS_Z = 2'd2;

    localparam logic HAND_1 = 1'b0;
    localparam logic HAND_2 = 1'b1;

    localparam int unsigned READS_PER_FRAME = 6;

    // Reads 0..2 belong to the starting hand, 3..5 to the other hand;
    // both halves walk x, y, z.
    function automatic logic [1:0] read_axis(input logic [2:0] idx);
        logic [2:0] a;
        a = (idx >= 3'd3) ? (idx - 3'd3) : idx;
        return a[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Sample period counter. Counts 0..PERIOD_CYCLES-1 while
//                enabled and wraps; held at 0 while disabled.
//  Ports       : clock  - system clock
//                reset  - synchronous, active-high
//                enable - run the counter
//                tick   - high in the last cycle of each period
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
    parameter int unsigned PERIOD_CYCLES = 270000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/hand_sample_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hand_sample_sched
//  Description : Shares one sensor read port between two hand sensors,
//                performs six axis reads per sample period into a shadow
//                frame and commits it atomically to x1..z2. Flags sensor
//                timeouts and period overruns.
//  Ports       : clock, reset          - clock, synchronous active-high reset
//                enable                - sampling enabled
//                rd_req/rd_hand/rd_axis- read request and address
//                rd_ack/rd_data        - read completion and data
//                x1..z2                - committed frame
//                frame_valid           - pulse, first cycle of a new frame
//                frame_err             - pulse, frame aborted on timeout
//                overrun               - pulse, tick while a frame is active
//                err_count             - saturating timeout count
//                busy                  - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module hand_sample_sched
    import gest_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 270000,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned W             = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic         rd_req,
    output logic         rd_hand,
    output logic [1:0]   rd_axis,
    input  logic         rd_ack,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] x1,
    output logic [W-1:0] y1,
    output logic [W-1:0] z1,
    output logic [W-1:0] x2,
    output logic [W-1:0] y2,
    output logic [W-1:0] z2,
    output logic         frame_valid,
    output logic         frame_err,
    output logic         overrun,
    output logic [7:0]   err_count,
    output logic         busy
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_READ = 3'(READS_PER_FRAME - 1);

    logic         tick;
    state_e       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [7:0]   wait_q, wait_d;
    logic         start_hand_q, start_hand_d;
    logic         cur_hand;
    logic [1:0]   cur_axis;
    logic         capture, commit, timeout_hit, overrun_d;
    logic [W-1:0] shadow_q [2][3];

    sample_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Second half of the frame reads the opposite hand.
    assign cur_hand = start_hand_q ^ (idx_q >= 3'd3);
    assign cur_axis = read_axis(idx_q);

    assign rd_req  = (state_q == ST_REQ);
    assign rd_hand = cur_hand;
    assign rd_axis = cur_axis;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        start_hand_d = start_hand_q;
        capture      = 1'b0;
        commit       = 1'b0;
        timeout_hit  = 1'b0;
        // A tick during a frame is reported and otherwise ignored.
        overrun_d    = tick && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_REQ;
                    idx_d   = 3'd0;
                    wait_d  = 8'd0;
                end
            end
            ST_REQ: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rd_ack) begin
                    // Ack takes priority over a timeout in the same cycle.
                    capture = 1'b1;
                    state_d = (idx_q == LAST_READ) ? ST_COMMIT : ST_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    wait_d  = 8'd0;
                    state_d = ST_REQ;
                end
            end
            ST_COMMIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    commit       = 1'b1;
                    start_hand_d = ~start_hand_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            wait_q       <= 8'd0;
            start_hand_q <= HAND_1;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            err_count    <= 8'd0;
            x1           <= '0;
            y1           <= '0;
            z1           <= '0;
            x2           <= '0;
            y2           <= '0;
            z2           <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            start_hand_q <= start_hand_d;
            frame_valid  <= commit;
            frame_err    <= timeout_hit;
            overrun      <= overrun_d;
            if (timeout_hit && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (commit) begin
                x1 <= shadow_q[HAND_1][AXIS_X];
                y1 <= shadow_q[HAND_1][AXIS_Y];
                z1 <= shadow_q[HAND_1][AXIS_Z];
                x2 <= shadow_q[HAND_2][AXIS_X];
                y2 <= shadow_q[HAND_2][AXIS_Y];
                z2 <= shadow_q[HAND_2][AXIS_Z];
            end
        end
    end

    // Shadow needs no reset: every path to COMMIT rewrites all six entries.
    always_ff @(posedge clock) begin
        if (capture) begin
            shadow_q[cur_hand][cur_axis] <= rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hand_sample_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hand_sample_sched
//  Description : Directed self-checking bench for hand_sample_sched with
//                PERIOD_CYCLES=16, TIMEOUT=4. Sensor responder returns
//                {hand at bit 12, 12'h5A0} + axis + salt after a
//                programmable ack delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hand_sample_sched;

    localparam int P  = 16;
    localparam int TO = 4;
    localparam int W  = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         rd_req, rd_hand, rd_ack;
    logic [1:0]   rd_axis;
    logic [W-1:0] rd_data;
    logic [W-1:0] x1, y1, z1, x2, y2, z2;
    logic         frame_valid, frame_err, overrun, busy;
    logic [7:0]   err_count;

    hand_sample_sched #(
        .PERIOD_CYCLES(P),
        .TIMEOUT      (TO),
        .W            (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rd_req      (rd_req),
        .rd_hand     (rd_hand),
        .rd_axis     (rd_axis),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .x1          (x1),
        .y1          (y1),
        .z1          (z1),
        .x2          (x2),
        .y2          (y2),
        .z2          (z2),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Sensor responder
    int         ack_delay = 0;
    logic       ack_en    = 1'b1;
    logic [W-1:0] salt    = '0;
    int         rq_cnt    = 0;

    assign rd_ack  = rd_req && ack_en && (rq_cnt == ack_delay);
    assign rd_data = {3'b000, rd_hand, 12'h5A0} + {14'b0, rd_axis} + salt;

    always @(posedge clock) rq_cnt <= (rd_req && !rd_ack) ? rq_cnt + 1 : 0;

    // Monitor: cumulative logs of the cycle just ending
    logic     req_prev = 1'b0;
    int       req_rise_q[$];
    logic [2:0] ack_tag_q[$];
    int       ack_cyc_q[$];
    int       ovr_q[$];
    int       req_total = 0;
    int       last_req  = -1;

    always @(posedge clock) begin
        req_prev <= rd_req;
        if (rd_req === 1'b1) begin
            if (req_prev !== 1'b1) req_rise_q.push_back(cyc);
            req_total = req_total + 1;
            last_req  = cyc;
            if (rd_ack === 1'b1) begin
                ack_tag_q.push_back({rd_hand, rd_axis});
                ack_cyc_q.push_back(cyc);
            end
        end
        if (overrun === 1'b1) ovr_q.push_back(cyc);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] smp(input logic h, input logic [1:0] a, input logic [W-1:0] s);
        return {3'b000, h, 12'h5A0} + {14'b0, a} + s;
    endfunction

    task automatic chk_frame(input string tag, input logic [W-1:0] s);
        chk({tag, "_x1"}, 32'(x1), 32'(smp(1'b0, 2'd0, s)));
        chk({tag, "_y1"}, 32'(y1), 32'(smp(1'b0, 2'd1, s)));
        chk({tag, "_z1"}, 32'(z1), 32'(smp(1'b0, 2'd2, s)));
        chk({tag, "_x2"}, 32'(x2), 32'(smp(1'b1, 2'd0, s)));
        chk({tag, "_y2"}, 32'(y2), 32'(smp(1'b1, 2'd1, s)));
        chk({tag, "_z2"}, 32'(z2), 32'(smp(1'b1, 2'd2, s)));
    endtask

    // Checks the six acked reads logged since index b in order starting at hand sh.
    task automatic chk_order(input string tag, input int b, input logic sh);
        chk({tag, "_nreads"}, 32'(ack_tag_q.size() - b), 32'd6);
        for (int k = 0; k < 6; k++) begin
            logic       h;
            logic [1:0] a;
            h = sh ^ (k >= 3);
            a = 2'(k % 3);
            if (ack_tag_q.size() > b + k)
                chk({tag, "_read"}, 32'(ack_tag_q[b + k]), 32'({h, a}));
        end
    endtask

    task automatic wait_frame(input int max, output int end_cyc, output logic was_err);
        end_cyc = -1;
        was_err = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (frame_valid === 1'b1 || frame_err === 1'b1) begin
                end_cyc = cyc;
                was_err = frame_err;
                break;
            end
        end
    endtask

    function automatic int rise_at(input int b);
        return (req_rise_q.size() > b) ? req_rise_q[b] : -1;
    endfunction

    int   e_cyc, fv, r, b_rise, b_ack, b_ovr, b_req, n_fv, n_err, ec255;
    logic err, exp_sh, seen;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        exp_sh = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_hand", 32'(rd_hand), 32'd0);
        chk("rst_axis", 32'(rd_axis), 32'd0);
        chk("rst_x1", 32'(x1), 32'd0);
        chk("rst_z2", 32'(z2), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Zero-wait frame: tick at E+15, reads at T+1,3,..,11, valid at T+13
        b_rise = req_rise_q.size();
        b_ack  = ack_tag_q.size();
        enable = 1'b1;
        e_cyc  = cyc;
        wait_frame(60, fv, err);
        r = rise_at(b_rise);
        chk("zw_first_req", 32'(r), 32'(e_cyc + 16));
        chk("zw_fv_cycle", 32'(fv), 32'(e_cyc + 28));
        chk("zw_err", 32'(err), 32'd0);
        chk_order("zw", b_ack, exp_sh);
        for (int k = 0; k < 6; k++)
            if (ack_cyc_q.size() > b_ack + k)
                chk("zw_read_cycle", 32'(ack_cyc_q[b_ack + k]), 32'(e_cyc + 16 + 2 * k));
        chk("zw_x1", 32'(x1), 32'h05A0);
        chk("zw_z2", 32'(z2), 32'h15A2);
        chk_frame("zw", '0);
        exp_sh = ~exp_sh;
        @(negedge clock);
        chk("zw_fv_pulse", 32'(frame_valid), 32'd0);

        // Second frame starts with hand 2
        b_ack = ack_tag_q.size();
        wait_frame(40, fv, err);
        chk("f2_fv_cycle", 32'(fv), 32'(e_cyc + 44));
        chk_order("f2", b_ack, exp_sh);
        chk_frame("f2", '0);
        exp_sh = ~exp_sh;

        // Wait states: 3-cycle ack delay, ack lands as wait counter hits TIMEOUT-1
        ack_delay = 3;
        salt      = 16'h0010;
        b_rise    = req_rise_q.size();
        b_ack     = ack_tag_q.size();
        wait_frame(80, fv, err);
        r = rise_at(b_rise);
        chk("ws_fv_cycle", 32'(fv), 32'(r + 30));
        chk("ws_err", 32'(err), 32'd0);
        chk("ws_errcnt", 32'(err_count), 32'd0);
        chk_order("ws", b_ack, exp_sh);
        chk_frame("ws", 16'h0010);
        exp_sh = ~exp_sh;

        // Overrun: 2-cycle ack delay, frame spans the next tick
        ack_delay = 2;
        salt      = 16'h0020;
        b_rise    = req_rise_q.size();
        b_ack     = ack_tag_q.size();
        b_ovr     = ovr_q.size();
        wait_frame(80, fv, err);
        r = rise_at(b_rise);
        chk("ov_fv_cycle", 32'(fv), 32'(r + 24));
        chk("ov_count", 32'(ovr_q.size() - b_ovr), 32'd1);
        if (ovr_q.size() > b_ovr)
            chk("ov_cycle", 32'(ovr_q[b_ovr]), 32'(r + 16));
        chk_order("ov", b_ack, exp_sh);
        chk_frame("ov", 16'h0020);
        exp_sh = ~exp_sh;

        // Timeout on the 4th read
        ack_delay = 0;
        salt      = 16'h0040;
        b_ack     = ack_tag_q.size();
        seen      = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (ack_tag_q.size() - b_ack == 3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("to_three_acks", 32'(seen), 32'd1);
        ack_en = 1'b0;
        b_req  = req_total;
        wait_frame(40, fv, err);
        chk("to_err_pulse", 32'(err), 32'd1);
        chk("to_req_cycles", 32'(req_total - b_req), 32'(TO));
        chk("to_err_cycle", 32'(fv), 32'(last_req + 1));
        chk("to_errcnt", 32'(err_count), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk_frame("to_hold", 16'h0020);

        // Next tick starts a fresh frame from read 1, same start hand
        ack_en = 1'b1;
        salt   = 16'h0080;
        b_rise = req_rise_q.size();
        b_ack  = ack_tag_q.size();
        wait_frame(40, fv, err);
        r = rise_at(b_rise);
        chk("rf_fv_cycle", 32'(fv), 32'(r + 12));
        chk("rf_err", 32'(err), 32'd0);
        chk_order("rf", b_ack, exp_sh);
        chk_frame("rf", 16'h0080);
        exp_sh = ~exp_sh;

        // Enable drop during read 3
        salt  = 16'h0100;
        b_ack = ack_tag_q.size();
        seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rd_req === 1'b1 && ack_tag_q.size() - b_ack == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ed_in_read3", 32'(seen), 32'd1);
        chk("ed_busy_req", 32'(busy), 32'd1);
        enable = 1'b0;
        @(negedge clock);
        chk("ed_req_low", 32'(rd_req), 32'd0);
        chk("ed_busy_low", 32'(busy), 32'd0);
        n_fv = 0;
        repeat (20) begin
            @(negedge clock);
            if (frame_valid === 1'b1 || frame_err === 1'b1) n_fv++;
        end
        chk("ed_no_frame", 32'(n_fv), 32'd0);
        chk_frame("ed_hold", 16'h0080);

        // Re-enable: timer restarted from 0, start hand unchanged
        b_rise = req_rise_q.size();
        b_ack  = ack_tag_q.size();
        enable = 1'b1;
        e_cyc  = cyc;
        wait_frame(60, fv, err);
        r = rise_at(b_rise);
        chk("re_first_req", 32'(r), 32'(e_cyc + 16));
        chk("re_fv_cycle", 32'(fv), 32'(e_cyc + 28));
        chk_order("re", b_ack, exp_sh);
        chk_frame("re", 16'h0100);

        // Reset during REQ
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (rd_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rm_in_req", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rm_req", 32'(rd_req), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_fv", 32'(frame_valid), 32'd0);
        chk("rm_x1", 32'(x1), 32'd0);
        chk("rm_z2", 32'(z2), 32'd0);
        chk("rm_errcnt", 32'(err_count), 32'd0);
        reset = 1'b0;

        // 300 forced timeouts: counter saturates at 255
        ack_en = 1'b0;
        n_err  = 0;
        ec255  = -1;
        for (int i = 0; i < 300; i++) begin
            wait_frame(40, fv, err);
            if (fv != -1 && err) n_err++;
            if (i == 254) ec255 = int'(err_count);
        end
        chk("sat_timeouts", 32'(n_err), 32'd300);
        chk("sat_at_255", 32'(ec255), 32'd255);
        chk("sat_final", 32'(err_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
